boot_sequencer: RTL and testbench

Sequences bring-up and exit of the USB bootloader on the Catena 4710 iCE40 image, in the clk_48mhz domain.
- Holds the bootloader core in reset until the 48 MHz PLL is locked and settled, then enables the USB pull-up.
- On a boot request from the core, detaches from USB so the host sees a disconnect, then drives SB_WARMBOOT (S1/S0/BOOT) to load the selected image.
- Replaces the fixed reset tie-off and fixed pull-up in the board top level.

---
 rtl/boot_sequencer.sv | 138 +++++++++++++
 tb/tb_boot_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// USB bootloader bring-up/exit sequencer: gates core reset and the USB pull-up on PLL lock,
// and hands off to SB_WARMBOOT after a host-visible detach.
module boot_sequencer #(
  parameter int         LOCK_SETTLE_CYCLES = 4800,
  parameter int         DETACH_CYCLES      = 480000,
  parameter logic [1:0] DEFAULT_IMAGE      = 2'b01,
  parameter int         CNT_W              = 20
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       boot_req,
  input  logic [1:0] image_sel,
  output logic       core_reset,
  output logic       usb_pu,
  output logic       wb_s1,
  output logic       wb_s0,
  output logic       wb_boot,
  output logic [2:0] state_dbg
);

  localparam int MAX_CYC = (LOCK_SETTLE_CYCLES > DETACH_CYCLES) ? LOCK_SETTLE_CYCLES
                                                                 : DETACH_CYCLES;

  generate
    if (LOCK_SETTLE_CYCLES < 1 || DETACH_CYCLES < 1) begin : g_bad_cycles
      $error("boot_sequencer: LOCK_SETTLE_CYCLES and DETACH_CYCLES must be nonzero");
    end
    if (CNT_W < 1 || CNT_W > 62 || 64'(MAX_CYC) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
      $error("boot_sequencer: CNT_W too small for the configured cycle counts");
    end
  endgenerate

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'(DETACH_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_DETACH = 3'd3,
    ST_BOOT   = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [1:0]       img_reg, img_next;
  logic             lock_meta_reg, lock_s_reg;
  logic             boot_req_d_reg;
  logic             boot_edge;
  logic             core_reset_reg, usb_pu_reg, wb_boot_reg;

  assign boot_edge = boot_req & ~boot_req_d_reg;
  assign cnt_inc   = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    img_next   = img_reg;
    case (state_reg)
      ST_HOLD: begin
        cnt_next = '0;
        if (lock_s_reg) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!lock_s_reg) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end else if (cnt_reg == SETTLE_LAST) begin
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_RUN: begin
        // Lock loss outranks a same-cycle boot request: no capture, back to HOLD.
        if (!lock_s_reg) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end else if (boot_edge) begin
          state_next = ST_DETACH;
          cnt_next   = '0;
          img_next   = image_sel;
        end
      end
      ST_DETACH: begin
        if (cnt_reg == DETACH_LAST) state_next = ST_BOOT;
        else                        cnt_next   = cnt_inc;
      end
      ST_BOOT: begin
        state_next = ST_BOOT;
      end
      default: begin
        state_next = ST_HOLD;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_reg  <= 1'b0;
      lock_s_reg     <= 1'b0;
      boot_req_d_reg <= 1'b0;
      state_reg      <= ST_HOLD;
      cnt_reg        <= '0;
      img_reg        <= DEFAULT_IMAGE;
      core_reset_reg <= 1'b1;
      usb_pu_reg     <= 1'b0;
      wb_boot_reg    <= 1'b0;
    end else begin
      lock_meta_reg  <= pll_lock;
      lock_s_reg     <= lock_meta_reg;
      boot_req_d_reg <= boot_req;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      img_reg        <= img_next;
      // Outputs decode the state being entered so they switch on the same edge.
      core_reset_reg <= (state_next == ST_HOLD) || (state_next == ST_SETTLE);
      usb_pu_reg     <= (state_next == ST_RUN);
      wb_boot_reg    <= (state_next == ST_BOOT);
    end
  end

  always_comb begin
    case (state_reg)
      ST_HOLD, ST_SETTLE, ST_RUN, ST_DETACH, ST_BOOT: state_dbg = state_reg;
      default:                                         state_dbg = 3'd7;
    endcase
  end

  assign core_reset = core_reset_reg;
  assign usb_pu     = usb_pu_reg;
  assign wb_boot    = wb_boot_reg;
  assign wb_s1      = img_reg[1];
  assign wb_s0      = img_reg[0];

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer with short settle/detach counts; edges are counted from reset release.
module tb_boot_sequencer;

  logic       clk_48mhz = 1'b0;
  logic       reset_n   = 1'b1;
  logic       pll_lock  = 1'b0;
  logic       boot_req  = 1'b0;
  logic [1:0] image_sel = 2'b00;
  logic       core_reset, usb_pu, wb_s1, wb_s0, wb_boot;
  logic [2:0] state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  boot_sequencer #(
    .LOCK_SETTLE_CYCLES(8),
    .DETACH_CYCLES(16),
    .DEFAULT_IMAGE(2'b01),
    .CNT_W(20)
  ) dut (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .pll_lock  (pll_lock),
    .boot_req  (boot_req),
    .image_sel (image_sel),
    .core_reset(core_reset),
    .usb_pu    (usb_pu),
    .wb_s1     (wb_s1),
    .wb_s0     (wb_s0),
    .wb_boot   (wb_boot),
    .state_dbg (state_dbg)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_48mhz);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic cr,
                         input logic pu, input logic [1:0] img, input logic wb);
    chk({tag, ".state"},      8'(state_dbg), 8'(st));
    chk({tag, ".core_reset"}, 8'(core_reset), 8'(cr));
    chk({tag, ".usb_pu"},     8'(usb_pu), 8'(pu));
    chk({tag, ".img"},        8'({wb_s1, wb_s0}), 8'(img));
    chk({tag, ".wb_boot"},    8'(wb_boot), 8'(wb));
  endtask

  // Assert reset asynchronously, check reset values before any clock edge, release on a falling edge.
  task automatic apply_reset(input string tag, input logic lock_during);
    reset_n   = 1'b0;
    boot_req  = 1'b0;
    pll_lock  = lock_during;
    #1;
    chk_all(tag, 3'd0, 1'b1, 1'b0, 2'b01, 1'b0);
    @(negedge clk_48mhz);
    @(negedge clk_48mhz);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset value check before the first clock edge.
    #2;
    apply_reset("rst", 1'b0);
    $display("[TB] reset released, lock low");

    // 1. Bring-up: lock sampled at edge 10, SETTLE at 12, RUN at 20.
    tick(9);
    pll_lock = 1'b1;
    tick(2);
    chk("bu.e11.state", 8'(state_dbg), 8'd0);
    tick(1);
    chk_all("bu.e12", 3'd1, 1'b1, 1'b0, 2'b01, 1'b0);
    tick(7);
    chk_all("bu.e19", 3'd1, 1'b1, 1'b0, 2'b01, 1'b0);
    tick(1);
    chk_all("bu.e20", 3'd2, 1'b0, 1'b1, 2'b01, 1'b0);
    $display("[TB] bring-up: RUN at edge 20");

    // RUN lock loss: dropped for edge 21, HOLD at 23 with outputs switching on that edge.
    pll_lock = 1'b0;
    tick(2);
    chk_all("runloss.e22", 3'd2, 1'b0, 1'b1, 2'b01, 1'b0);
    tick(1);
    chk_all("runloss.e23", 3'd0, 1'b1, 1'b0, 2'b01, 1'b0);

    // 2. Lock glitch at SETTLE count 5: SETTLE at 26, lock_s low during count 5, HOLD 32, SETTLE 33, RUN 41.
    pll_lock = 1'b1;
    tick(3);
    chk("gl.e26.state", 8'(state_dbg), 8'd1);
    tick(3);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    chk("gl.e31.state", 8'(state_dbg), 8'd1);
    tick(1);
    chk_all("gl.e32", 3'd0, 1'b1, 1'b0, 2'b01, 1'b0);
    tick(1);
    chk("gl.e33.state", 8'(state_dbg), 8'd1);
    tick(7);
    chk_all("gl.e40", 3'd1, 1'b1, 1'b0, 2'b01, 1'b0);
    tick(1);
    chk_all("gl.e41", 3'd2, 1'b0, 1'b1, 2'b01, 1'b0);
    $display("[TB] lock glitch: fresh SETTLE, RUN at edge 41");

    // 3. Boot: request at 42 held 3 cycles, DETACH 42..57, BOOT at 58.
    image_sel = 2'b10;
    boot_req  = 1'b1;
    tick(1);
    chk_all("bt.e42", 3'd3, 1'b0, 1'b0, 2'b10, 1'b0);
    image_sel = 2'b11;
    tick(2);
    boot_req = 1'b0;
    tick(13);
    chk_all("bt.e57", 3'd3, 1'b0, 1'b0, 2'b10, 1'b0);
    tick(1);
    chk_all("bt.e58", 3'd4, 1'b0, 1'b0, 2'b10, 1'b1);
    boot_req = 1'b1;
    tick(1);
    boot_req = 1'b0;
    tick(3);
    chk_all("bt.late", 3'd4, 1'b0, 1'b0, 2'b10, 1'b1);
    $display("[TB] boot: image 2 captured, wb_boot after 16 detach cycles");

    // 4. Same-cycle lock loss and boot edge at edge 14: HOLD wins, no capture.
    apply_reset("rst4", 1'b1);
    tick(11);
    chk("sim.e11.state", 8'(state_dbg), 8'd2);
    pll_lock = 1'b0;
    tick(2);
    image_sel = 2'b10;
    boot_req  = 1'b1;
    tick(1);
    chk_all("sim.e14", 3'd0, 1'b1, 1'b0, 2'b01, 1'b0);
    boot_req = 1'b0;
    tick(20);
    chk_all("sim.later", 3'd0, 1'b1, 1'b0, 2'b01, 1'b0);
    $display("[TB] simultaneous: lock loss won, no capture");

    // 5a. Lock loss during DETACH is ignored: DETACH at 12, BOOT at 28.
    apply_reset("rst5a", 1'b1);
    tick(11);
    image_sel = 2'b11;
    boot_req  = 1'b1;
    tick(1);
    chk("cm.e12.state", 8'(state_dbg), 8'd3);
    boot_req = 1'b0;
    pll_lock = 1'b0;
    tick(15);
    chk_all("cm.e27", 3'd3, 1'b0, 1'b0, 2'b11, 1'b0);
    tick(1);
    chk_all("cm.e28", 3'd4, 1'b0, 1'b0, 2'b11, 1'b1);
    $display("[TB] commit: BOOT on schedule despite lock loss");

    // 5b. Reset at DETACH count 7 (after edge 19) restores reset values without a clock edge.
    apply_reset("rst5b", 1'b1);
    tick(11);
    image_sel = 2'b00;
    boot_req  = 1'b1;
    tick(1);
    boot_req = 1'b0;
    tick(7);
    chk_all("rs.e19", 3'd3, 1'b0, 1'b0, 2'b00, 1'b0);
    #2;
    apply_reset("rs.async", 1'b0);
    $display("[TB] mid-DETACH reset: outputs back to reset values");

    // 6. Requests in HOLD and SETTLE, and a level held into RUN, are all ignored.
    tick(2);
    boot_req = 1'b1;
    tick(1);
    chk("er.hold.state", 8'(state_dbg), 8'd0);
    boot_req = 1'b0;
    pll_lock = 1'b1;
    tick(4);
    chk("er.e7.state", 8'(state_dbg), 8'd1);
    boot_req = 1'b1;
    tick(1);
    boot_req = 1'b0;
    tick(4);
    boot_req = 1'b1;
    tick(2);
    chk_all("er.e14", 3'd2, 1'b0, 1'b1, 2'b01, 1'b0);
    tick(5);
    chk_all("er.e19", 3'd2, 1'b0, 1'b1, 2'b01, 1'b0);
    boot_req = 1'b0;
    $display("[TB] early requests: ignored, RUN held");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
